// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR multiply/accumulate sequencer.
package fir_seq_pkg;

  localparam int IN_W_DEF  = 3;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_MAC1,
    S_MAC2,
    S_MAC3,
    S_DONE
  } state_t;

  // Tap select codes understood by the accumulator; MUL_T1 restarts it from zero.
  localparam logic [3:0] MUL_NONE = 4'b0000;
  localparam logic [3:0] MUL_T1   = 4'b0001;
  localparam logic [3:0] MUL_T2   = 4'b0010;
  localparam logic [3:0] MUL_T3   = 4'b0011;

endpackage

// File: rtl/fir_mac_seq_if.sv
// Signal bundle between the sequencer, the sample source, the coefficient RAM and the accumulator.
interface fir_mac_seq_if #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 4
) ();

  logic                    iEnSample;
  logic signed [IN_W-1:0]  iFirIn;
  logic                    iCoeffUpdate;
  logic                    iClrOvr;
  logic signed [OUT_W-1:0] iAccOut;

  logic                    oCsnRam;
  logic [ADDR_W-1:0]       oAddrRam;
  logic [3:0]              oEnMul;
  logic                    oEnAdd;
  logic                    oEnAcc;
  logic signed [IN_W-1:0]  oDelay1;
  logic signed [IN_W-1:0]  oDelay2;
  logic signed [IN_W-1:0]  oDelay3;
  logic signed [OUT_W-1:0] oFirOut;
  logic                    oFirValid;
  logic                    oBusy;
  logic                    oOverrun;

  // Sequencer side.
  modport master (
    input  iEnSample, iFirIn, iCoeffUpdate, iClrOvr, iAccOut,
    output oCsnRam, oAddrRam, oEnMul, oEnAdd, oEnAcc,
           oDelay1, oDelay2, oDelay3, oFirOut, oFirValid, oBusy, oOverrun
  );

  // Environment side: sample source, RAM and accumulator.
  modport slave (
    output iEnSample, iFirIn, iCoeffUpdate, iClrOvr, iAccOut,
    input  oCsnRam, oAddrRam, oEnMul, oEnAdd, oEnAcc,
           oDelay1, oDelay2, oDelay3, oFirOut, oFirValid, oBusy, oOverrun
  );

endinterface

// File: rtl/fir_delay_line.sv
// Three-stage signed sample shift register; d1 is the newest sample.
module fir_delay_line #(
  parameter int IN_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift,
  input  logic signed [IN_W-1:0] din,
  output logic signed [IN_W-1:0] d1,
  output logic signed [IN_W-1:0] d2,
  output logic signed [IN_W-1:0] d3
);

  // NOTE: non-blocking assignments make all three stages sample their old neighbour at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (shift) begin
      d3 <= d2;
      d2 <= d1;
      d1 <= din;
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Per-sample sequencer for the 3-tap transposed FIR: shifts samples, reads coefficients,
// steps the accumulator through its taps and captures the finished result.
module fir_mac_seq
  import fir_seq_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int ADDR_W     = 4,
  parameter int COEFF_BASE = 0
) (
  input  logic           iClk_12M,
  input  logic           iRsn,
  fir_mac_seq_if.master  bus
);

  localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(COEFF_BASE);
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(COEFF_BASE + 1);
  localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(COEFF_BASE + 2);

  state_t state, state_nxt;
  logic   accept;
  logic   drop;

  // A strobe starts a sequence only from IDLE with the RAM stable; anything else is lost.
  assign accept = (state == S_IDLE) && bus.iEnSample && !bus.iCoeffUpdate;
  assign drop   = bus.iEnSample && !accept;

  fir_delay_line #(.IN_W(IN_W)) u_delay (
    .clk   (iClk_12M),
    .rst_n (iRsn),
    .shift (accept),
    .din   (bus.iFirIn),
    .d1    (bus.oDelay1),
    .d2    (bus.oDelay2),
    .d3    (bus.oDelay3)
  );

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // RAM reads run one state ahead of the tap that consumes the coefficient.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latches).
    state_nxt    = state;
    bus.oCsnRam  = 1'b1;
    bus.oAddrRam = BASE0;
    bus.oEnMul   = MUL_NONE;
    bus.oEnAdd   = 1'b0;
    bus.oEnAcc   = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_nxt = S_ADDR;
      S_ADDR: begin
        state_nxt   = S_MAC1;
        bus.oCsnRam = 1'b0;
      end
      S_MAC1: begin
        state_nxt    = S_MAC2;
        bus.oCsnRam  = 1'b0;
        bus.oAddrRam = BASE1;
        bus.oEnMul   = MUL_T1;
        bus.oEnAdd   = 1'b1;
        bus.oEnAcc   = 1'b1;
      end
      S_MAC2: begin
        state_nxt    = S_MAC3;
        bus.oCsnRam  = 1'b0;
        bus.oAddrRam = BASE2;
        bus.oEnMul   = MUL_T2;
        bus.oEnAdd   = 1'b1;
        bus.oEnAcc   = 1'b1;
      end
      S_MAC3: begin
        state_nxt  = S_DONE;
        bus.oEnMul = MUL_T3;
        bus.oEnAdd = 1'b1;
        bus.oEnAcc = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.oBusy = (state != S_IDLE);

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      bus.oFirOut   <= '0;
      bus.oFirValid <= 1'b0;
    end else begin
      bus.oFirValid <= (state == S_DONE);
      if (state == S_DONE) bus.oFirOut <= bus.iAccOut;
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn)              bus.oOverrun <= 1'b0;
    else if (drop)          bus.oOverrun <= 1'b1;
    else if (bus.iClrOvr)   bus.oOverrun <= 1'b0;
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq with a coefficient RAM and accumulator model; results checked via scoreboard.
module tb_fir_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic signed [15:0] exp_q[$];

  fir_mac_seq_if #(.IN_W(3), .OUT_W(16), .ADDR_W(4)) bus  ();
  fir_mac_seq_if #(.IN_W(3), .OUT_W(16), .ADDR_W(4)) bus2 ();

  fir_mac_seq #(.IN_W(3), .OUT_W(16), .ADDR_W(4), .COEFF_BASE(0)) u_dut (
    .iClk_12M (clk),
    .iRsn     (rst_n),
    .bus      (bus)
  );

  fir_mac_seq #(.IN_W(3), .OUT_W(16), .ADDR_W(4), .COEFF_BASE(8)) u_dut8 (
    .iClk_12M (clk),
    .iRsn     (rst_n),
    .bus      (bus2)
  );

  always #5 clk = ~clk;

  // Coefficient RAM (synchronous read) and 3-tap accumulator model.
  logic signed [7:0] ram [16];
  logic signed [7:0] ram_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q       <= '0;
      bus.iAccOut <= '0;
    end else begin
      if (!bus.oCsnRam) ram_q <= ram[bus.oAddrRam];
      if (bus.oEnAcc) begin
        case (bus.oEnMul)
          4'b0001: bus.iAccOut <= 16'(int'(ram_q) * int'(bus.oDelay1));
          4'b0010: bus.iAccOut <= bus.iAccOut + 16'(int'(ram_q) * int'(bus.oDelay2));
          4'b0011: bus.iAccOut <= bus.iAccOut + 16'(int'(ram_q) * int'(bus.oDelay3));
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.oFirValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got oFirOut=%0h expected no valid", bus.oFirOut);
      end else begin
        logic signed [15:0] e;
        e = exp_q.pop_front();
        check("fir_out", 32'(bus.oFirOut), 32'(e));
      end
    end
  end

  // Decoded outputs per cycle t1..t6 for base 0: {csn, addr, mul, add, acc, busy}.
  logic [11:0] exp_dec [1:6];
  initial begin
    exp_dec[1] = 12'b0_0000_0000_001;
    exp_dec[2] = 12'b0_0001_0001_111;
    exp_dec[3] = 12'b0_0010_0010_111;
    exp_dec[4] = 12'b1_0000_0011_111;
    exp_dec[5] = 12'b1_0000_0000_001;
    exp_dec[6] = 12'b1_0000_0000_000;
  end

  function automatic logic [11:0] dec_now();
    return {bus.oCsnRam, bus.oAddrRam, bus.oEnMul, bus.oEnAdd, bus.oEnAcc, bus.oBusy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe a sample in the current cycle (t0) and walk t1..t6; returns in t6 (IDLE).
  task automatic run_seq(input logic signed [2:0] s, input logic signed [15:0] exp_out,
                         input logic signed [2:0] e1, input logic signed [2:0] e2,
                         input logic signed [2:0] e3, input int inject_at);
    bus.iEnSample = 1'b1;
    bus.iFirIn    = s;
    exp_q.push_back(exp_out);
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus.iEnSample = (k == inject_at);
      bus.iFirIn    = 3'sd3;
      check($sformatf("decode_t%0d", k), 32'(dec_now()), 32'(exp_dec[k]));
      if (k == 1)
        check("delays_t1", 32'({bus.oDelay1, bus.oDelay2, bus.oDelay3}), 32'({e1, e2, e3}));
    end
    check("valid_t6", 32'(bus.oFirValid), 32'd1);
  endtask

  initial begin
    int vcnt;
    int n;
    logic [3:0] addrs [3];

    ram[0] = 8'sd2;
    ram[1] = 8'sd3;
    ram[2] = -8'sd1;
    for (int i = 3; i < 16; i++) ram[i] = 8'sd0;

    rst_n = 1'b0;
    bus.iEnSample = 1'b0; bus.iFirIn = '0; bus.iCoeffUpdate = 1'b0; bus.iClrOvr = 1'b0;
    bus2.iEnSample = 1'b0; bus2.iFirIn = '0; bus2.iCoeffUpdate = 1'b0; bus2.iClrOvr = 1'b0;
    bus2.iAccOut = '0;
    tick(); tick();
    check("reset_decode", 32'(dec_now()), 32'(12'b1_0000_0000_000));
    check("reset_regs", 32'({bus.oDelay1, bus.oDelay2, bus.oDelay3, bus.oFirValid, bus.oOverrun}), 32'd0);
    check("reset_fir_out", 32'(bus.oFirOut), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset in MAC2 aborts the sequence at once.
    bus.iEnSample = 1'b1; bus.iFirIn = 3'sd1;
    tick();
    bus.iEnSample = 1'b0;
    tick(); tick();
    check("pre_reset_mac2", 32'(bus.oEnMul), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_decode", 32'(dec_now()), 32'(12'b1_0000_0000_000));
    check("mid_reset_delays", 32'({bus.oDelay1, bus.oDelay2, bus.oDelay3}), 32'd0);
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.oFirValid) vcnt++;
    end
    check("no_valid_after_reset", 32'(vcnt), 32'd0);

    // Single sample then back-to-back samples at minimum spacing.
    run_seq(3'sd1, 16'sd2, 3'sd1, 3'sd0, 3'sd0, 0);
    run_seq(3'sd2, 16'sd7, 3'sd2, 3'sd1, 3'sd0, 0);
    run_seq(-3'sd3, -16'sd1, -3'sd3, 3'sd2, 3'sd1, 0);

    // Strobe at t3 is dropped: 2*1 + 3*(-3) + (-1)*2 = -9.
    run_seq(3'sd1, -16'sd9, 3'sd1, -3'sd3, 3'sd2, 3);
    check("overrun_set", 32'(bus.oOverrun), 32'd1);
    check("delays_after_drop", 32'({bus.oDelay1, bus.oDelay2, bus.oDelay3}),
          32'({3'sd1, -3'sd3, 3'sd2}));
    tick();

    // Clear together with a dropped strobe: set wins.
    bus.iCoeffUpdate = 1'b1; bus.iEnSample = 1'b1; bus.iClrOvr = 1'b1;
    tick();
    bus.iEnSample = 1'b0;
    check("clr_vs_set", 32'(bus.oOverrun), 32'd1);
    tick();
    bus.iClrOvr = 1'b0;
    check("clr_alone", 32'(bus.oOverrun), 32'd0);

    // Coefficient update blocks a start from IDLE.
    bus.iEnSample = 1'b1; bus.iFirIn = -3'sd1;
    tick();
    bus.iEnSample = 1'b0;
    check("coeff_upd_busy", 32'(bus.oBusy), 32'd0);
    check("coeff_upd_ovr", 32'(bus.oOverrun), 32'd1);
    check("coeff_upd_delays", 32'({bus.oDelay1, bus.oDelay2, bus.oDelay3}),
          32'({3'sd1, -3'sd3, 3'sd2}));
    bus.iCoeffUpdate = 1'b0;
    bus.iClrOvr = 1'b1;
    tick();
    bus.iClrOvr = 1'b0;
    // -1*2 + 1*3 + (-3)*(-1) = 4
    run_seq(-3'sd1, 16'sd4, -3'sd1, 3'sd1, -3'sd3, 0);
    tick();

    // COEFF_BASE=8 instance issues 8,9,10 with chip-select low exactly three cycles.
    bus2.iEnSample = 1'b1;
    tick();
    bus2.iEnSample = 1'b0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (!bus2.oCsnRam) begin
        if (n < 3) addrs[n] = bus2.oAddrRam;
        n++;
      end
      tick();
    end
    check("base8_csn_cycles", 32'(n), 32'd3);
    check("base8_addr0", 32'(addrs[0]), 32'd8);
    check("base8_addr1", 32'(addrs[1]), 32'd9);
    check("base8_addr2", 32'(addrs[2]), 32'd10);

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Sequencer that drives the 3-tap multiply/accumulate datapath of the transposed FIR filter. For each accepted input sample it:
- shifts a 3-stage sample delay line;
- fetches the three coefficients from the synchronous coefficient RAM;
- issues the per-tap enable codes (iEnMul/iEnAdd/iEnAcc) to the accumulator;
- captures the finished 16-bit accumulator result with a valid pulse.

It sits between the sample source and the accumulator, and owns the coefficient RAM read port.

Parameters:
IN_W, 3, signed input sample width (= accumulator iDelay width)
OUT_W, 16, accumulator result width
ADDR_W, 4, coefficient RAM address width
COEFF_BASE, 0, RAM address of tap-1 coefficient; taps 2/3 at +1/+2

Ports:
iClk_12M  in  1  system clock, 12 MHz
iRsn  in  1  asynchronous active-low reset
iEnSample  in  1  one-cycle strobe: iFirIn valid
iFirIn  in  IN_W  signed input sample
iCoeffUpdate  in  1  coefficient RAM being rewritten; blocks new sequences
iClrOvr  in  1  clears oOverrun
iAccOut  in  OUT_W  accumulator registered output (oFirOut of accumulator)
oCsnRam  out  1  coefficient RAM chip-select, active-low
oAddrRam  out  ADDR_W  coefficient RAM read address
oEnMul  out  4  tap select to accumulator: 0001/0010/0011, else 0000
oEnAdd  out  1  accumulator add enable
oEnAcc  out  1  accumulator register enable
oDelay1  out  IN_W  newest sample (tap 1)
oDelay2  out  IN_W  previous sample (tap 2)
oDelay3  out  IN_W  oldest sample (tap 3)
oFirOut  out  OUT_W  captured filter output
oFirValid  out  1  one-cycle pulse, oFirOut updated
oBusy  out  1  state != IDLE
oOverrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset (async, iRsn=0):
  - state IDLE; delay line, oFirOut, oFirValid, oOverrun all 0;
  - oCsnRam=1; oAddrRam=COEFF_BASE; oEnMul=0, oEnAdd=0, oEnAcc=0.
  - Reset mid-sequence aborts immediately; no valid pulse follows.
- RAM timing: synchronous read, address at cycle N gives data on the accumulator iCoeff at cycle N+1.
- FSM: IDLE -> ADDR -> MAC1 -> MAC2 -> MAC3 -> DONE -> IDLE. All transitions are unconditional except leaving IDLE.
- IDLE:
  - If iEnSample=1 and iCoeffUpdate=0: at the edge, oDelay3<=oDelay2, oDelay2<=oDelay1, oDelay1<=iFirIn; go to ADDR.
  - If iEnSample=1 and iCoeffUpdate=1: sample dropped, oOverrun set.
- Decoded outputs (combinational from state; values not listed are 0 / oCsnRam=1 / oAddrRam=COEFF_BASE):
  - ADDR: oCsnRam=0, oAddrRam=BASE.
  - MAC1: oCsnRam=0, oAddrRam=BASE+1, oEnMul=0001, oEnAdd=1, oEnAcc=1. Accumulator restarts from 0 on code 0001.
  - MAC2: oCsnRam=0, oAddrRam=BASE+2, oEnMul=0010, oEnAdd=1, oEnAcc=1.
  - MAC3: oEnMul=0011, oEnAdd=1, oEnAcc=1; RAM deselected.
  - DONE: oFirOut<=iAccOut and oFirValid<=1 at the edge, so both are visible in the following (IDLE) cycle.
- oFirValid: high exactly one cycle.
- Latency: strobe cycle t0 -> oFirValid at t6. Minimum sample spacing is 6 cycles; a strobe in the IDLE cycle at t6 is accepted.
- Overrun:
  - iEnSample in any non-IDLE state is dropped and sets oOverrun; the running sequence is unaffected.
  - iClrOvr clears oOverrun; a simultaneous set wins.
- iCoeffUpdate rising mid-sequence: the sequence completes; only new starts are blocked.
- Arithmetic: no arithmetic here. Delay line holds signed IN_W samples. oFirOut is a verbatim copy of iAccOut (signed, two's complement).

Decomposition:
- Package fir_seq_pkg:
  - state encoding (IDLE, ADDR, MAC1, MAC2, MAC3, DONE);
  - tap codes MUL_T1=4'b0001, MUL_T2=4'b0010, MUL_T3=4'b0011, MUL_NONE=4'b0000;
  - IN_W/OUT_W defaults.
- One sub-module, fir_delay_line: 3-stage signed shift register with shift enable and async active-low clear. The FSM and output decode stay in fir_mac_seq.

Test Plan:
- Reset mid-sequence: assert iRsn=0 in MAC2 -> all outputs at reset values immediately; no oFirValid afterwards; next sample starts cleanly from ADDR.
- Single sample, RAM[0..2]={2,3,-1}, iFirIn=1 -> oEnMul sequence 0001,0010,0011 at t2..t4; oAddrRam 0,1,2 at t1..t3; bench accumulator model yields oFirOut=2, oFirValid at t6.
- Back-to-back samples 2 then -3, spaced 6 cycles:
  - first: delays (2,1,0), oFirOut=7;
  - second: delays (-3,2,1), oFirOut=16'hFFFF (-1).
- Strobe at t3 of a running sequence -> oOverrun=1; delays unchanged; current result still delivered at t6. Then iClrOvr together with a new dropped strobe -> oOverrun stays 1.
- iCoeffUpdate=1 in IDLE, iEnSample=1 -> no state change, oBusy=0, oOverrun=1. Release iCoeffUpdate and strobe -> normal sequence.
- COEFF_BASE=8 instance -> addresses 8,9,10 issued; oCsnRam low for exactly 3 cycles per sample.
